// File: rtl/agusec_resolve_pkg.sv
// Shared constants and types for the AGU security-check resolve stage:
// ack index encoding, fault counter width and the per-op check record.
package agusec_resolve_pkg;

  localparam int IDX_C0   = 0;
  localparam int IDX_C1   = 1;
  localparam int IDX_WIDE = 2;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [1:0] idx_t;

  // Upstream check results for one op, held in S1 until the select runs.
  typedef struct packed {
    logic [2:0] pos_ack;
    logic [2:0] neg_ack;
    logic [1:0] pos_flip;
    logic [1:0] neg_flip;
    logic       carry;
    logic       neg;
    logic       wide;
    logic       range_ok;
  } chk_t;

  function automatic idx_t ack_idx(input logic carry, input logic wide);
    if (wide) return idx_t'(IDX_WIDE);
    return carry ? idx_t'(IDX_C1) : idx_t'(IDX_C0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/agusec_resolve_if.sv
// Handshake and status bundle of the resolve stage; master drives the op
// stream and consumes results, slave is the stage itself.
interface agusec_resolve_if
  import agusec_resolve_pkg::*;
#(
  parameter int TAG_W = 9
) ();

  logic             flush;
  logic             in_vld;
  logic             in_rdy;
  logic [TAG_W-1:0] in_tag;
  logic [2:0]       in_pos_ack;
  logic [2:0]       in_neg_ack;
  logic [1:0]       in_pos_flip;
  logic [1:0]       in_neg_flip;
  logic             in_carry;
  logic             in_neg;
  logic             in_wide;
  logic             in_range_ok;

  logic             out_vld;
  logic             out_rdy;
  logic [TAG_W-1:0] out_tag;
  logic             out_ok;
  logic             out_flip;

  logic [CNT_W-1:0] flt_cnt;
  logic             ff_vld;
  logic [TAG_W-1:0] ff_tag;
  logic             ff_clr;

  modport master (
    output flush, in_vld, in_tag, in_pos_ack, in_neg_ack, in_pos_flip,
           in_neg_flip, in_carry, in_neg, in_wide, in_range_ok, out_rdy, ff_clr,
    input  in_rdy, out_vld, out_tag, out_ok, out_flip, flt_cnt, ff_vld, ff_tag
  );

  modport slave (
    input  flush, in_vld, in_tag, in_pos_ack, in_neg_ack, in_pos_flip,
           in_neg_flip, in_carry, in_neg, in_wide, in_range_ok, out_rdy, ff_clr,
    output in_rdy, out_vld, out_tag, out_ok, out_flip, flt_cnt, ff_vld, ff_tag
  );

endinterface

// File: rtl/agusec_resolve_sel.sv
// Combinational ack/flip select: picks the carry-case result matching the
// op's sign, carry and width, then gates it with the range comparator.
module agusec_resolve_sel
  import agusec_resolve_pkg::*;
(
  input  chk_t chk,
  output logic ok,
  output logic flip
);

  idx_t idx;
  logic ack;
  logic flip_raw;

  // NOTE: combinational logic uses blocking assignments; registers use <=.
  always_comb begin
    idx      = ack_idx(chk.carry, chk.wide);
    ack      = chk.neg ? chk.neg_ack[idx] : chk.pos_ack[idx];
    flip_raw = chk.neg ? chk.neg_flip[chk.carry] : chk.pos_flip[chk.carry];
    ok       = ack & chk.range_ok;
    // A wide access never flips, and a failing op reports no flip either.
    flip     = ok & ~chk.wide & flip_raw;
  end

endmodule

// File: rtl/agusec_resolve.sv
// Two-stage resolve pipeline: S1 captures upstream check results, S2 holds
// the selected verdict; also keeps the fault counter and first-fault record.
module agusec_resolve
  import agusec_resolve_pkg::*;
#(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  agusec_resolve_if.slave  bus
);

  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;
  chk_t             s1_chk;

  logic             s2_vld;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_ok;
  logic             s2_flip;

  logic [CNT_W-1:0] flt_q;
  logic             ff_vld_q;
  logic [TAG_W-1:0] ff_tag_q;

  logic s2_free;
  logic in_rdy;
  logic in_fire;
  logic s1_adv;
  logic out_fire;
  logic fault;
  logic sel_ok;
  logic sel_flip;

  // NOTE: every output of this block is assigned on every path, so no latch.
  always_comb begin
    s2_free  = ~s2_vld | bus.out_rdy;
    in_rdy   = ~s1_vld | s2_free;
    in_fire  = bus.in_vld & in_rdy & ~bus.flush;
    s1_adv   = s1_vld & s2_free;
    out_fire = s2_vld & bus.out_rdy;
    fault    = out_fire & ~s2_ok;
  end

  // S1 valid: flush wins, a new op refills, an advance empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (bus.flush) begin
      s1_vld <= 1'b0;
    end else if (in_fire) begin
      s1_vld <= 1'b1;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // NOTE: S1 payload has no reset; it is only consumed behind s1_vld.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_tag <= bus.in_tag;
      s1_chk <= '{pos_ack:  bus.in_pos_ack,
                  neg_ack:  bus.in_neg_ack,
                  pos_flip: bus.in_pos_flip,
                  neg_flip: bus.in_neg_flip,
                  carry:    bus.in_carry,
                  neg:      bus.in_neg,
                  wide:     bus.in_wide,
                  range_ok: bus.in_range_ok};
    end
  end

  agusec_resolve_sel u_sel (
    .chk  (s1_chk),
    .ok   (sel_ok),
    .flip (sel_flip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
    end else if (bus.flush) begin
      s2_vld <= 1'b0;
    end else if (s1_adv) begin
      s2_vld <= 1'b1;
    end else if (out_fire) begin
      s2_vld <= 1'b0;
    end
  end

  // S2 payload is visible on the outputs, so it is reset to a known 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_tag  <= '0;
      s2_ok   <= 1'b0;
      s2_flip <= 1'b0;
    end else if (s1_adv) begin
      s2_tag  <= s1_tag;
      s2_ok   <= sel_ok;
      s2_flip <= sel_flip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q <= '0;
    end else if (fault) begin
      flt_q <= sat_inc(flt_q);
    end
  end

  // A clear that lands on a faulting handshake re-arms and captures at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld_q <= 1'b0;
      ff_tag_q <= '0;
    end else if (fault && (!ff_vld_q || bus.ff_clr)) begin
      ff_vld_q <= 1'b1;
      ff_tag_q <= s2_tag;
    end else if (bus.ff_clr) begin
      ff_vld_q <= 1'b0;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = s2_vld;
  assign bus.out_tag  = s2_tag;
  assign bus.out_ok   = s2_ok;
  assign bus.out_flip = s2_flip;
  assign bus.flt_cnt  = flt_q;
  assign bus.ff_vld   = ff_vld_q;
  assign bus.ff_tag   = ff_tag_q;

endmodule

// File: doc/agusec_resolve.md
AGUSEC_RESOLVE -- requirements
Module: agusec_resolve

Interface
REQ-001 Parameter TAG_W, default 9: width of the op tag carried through the stage.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  kill all in-flight entries this cycle.
REQ-005 in_vld  in  1  upstream check results valid.
REQ-006 in_rdy  out  1  stage can accept in this cycle.
REQ-007 in_tag  in  TAG_W  op identifier.
REQ-008 in_pos_ack  in  3  upper-range ack per carry case {wide, c=1, c=0}.
REQ-009 in_neg_ack  in  3  lower-range ack per carry case {wide, c=1, c=0}.
REQ-010 in_pos_flip, in_neg_flip  in  2 each  on_low flip request per carry case {c=1, c=0}.
REQ-011 in_carry  in  1  address-add carry into the checked field.
REQ-012 in_neg  in  1  offset negative (select neg_*).
REQ-013 in_wide  in  1  multi-granule access (select index 2).
REQ-014 in_range_ok  in  1  low/high range comparator pass (cout_secq).
REQ-015 out_vld  out  1;  out_rdy  in  1  downstream handshake.
REQ-016 out_tag  out  TAG_W;  out_ok  out  1;  out_flip  out  1.
REQ-017 flt_cnt  out  16  saturating count of faulting ops.
REQ-018 ff_vld  out  1;  ff_tag  out  TAG_W  sticky first-fault record;  ff_clr  in  1  clear it.

Function
REQ-019 Two-stage pipeline S1 (input register), S2 (output register) SHALL give latency 2 cycles from in handshake to out_vld when unstalled; throughput 1/cycle.
REQ-020 Input handshake occurs when in_vld & in_rdy; output handshake when out_vld & out_rdy.
REQ-021 in_rdy SHALL equal ~s1_vld | (~s2_vld | out_rdy), combinationally, independent of in_vld.
REQ-022 S1 advances to S2 when s1_vld & (~s2_vld | out_rdy); S2 holds its contents stable while out_vld & ~out_rdy.
REQ-023 idx = in_wide ? 2 : in_carry; evaluated in S2 from S1-registered fields.
REQ-024 ack = in_neg ? neg_ack[idx] : pos_ack[idx]; out_ok = ack & range_ok.
REQ-025 out_flip = in_wide ? 0 : (in_neg ? neg_flip[in_carry] : pos_flip[in_carry]); forced 0 when out_ok=0.
REQ-026 out_tag SHALL be the in_tag captured with the same op.
REQ-027 flush SHALL clear s1_vld and s2_vld at the next edge; in_vld ignored in the flush cycle; out_vld low the following cycle.
REQ-028 flt_cnt increments by 1 on each output handshake with out_ok=0, saturating at 16'hFFFF; unaffected by flush.
REQ-029 On output handshake with out_ok=0 and ff_vld=0: ff_vld<=1, ff_tag<=out_tag; further faults leave ff_tag unchanged.
REQ-030 ff_clr clears ff_vld; if ff_clr coincides with a faulting handshake, the new fault SHALL be captured (ff_vld=1, new tag).
REQ-031 Payload registers load only on their stage's enable; no X propagation from payload when valid low.

Reset
REQ-032 rst SHALL asynchronously clear s1_vld, s2_vld, out_vld, flt_cnt, ff_vld, ff_tag, out_ok, out_flip, out_tag to 0.
REQ-033 Reset mid-operation SHALL discard all in-flight ops without counting faults; in_rdy=1 on first cycle after deassertion.

Structure
REQ-034 Ack index constants (IDX_C0=0, IDX_C1=1, IDX_WIDE=2) and the 16-bit counter width SHALL live in the shared agusec package.
REQ-035 One sub-module agusec_resolve_sel (combinational ack/flip select, REQ-023..025) SHALL be instantiated in S2; pipeline and counters remain in top.

Verification
REQ-036 in_pos_ack=3'b010, in_carry=1, in_neg=0, in_range_ok=1, tag=5 -> out_vld 2 cycles later, out_ok=1, out_tag=5, flt_cnt=0.
REQ-037 in_neg=1, in_wide=1, in_neg_ack=3'b011, tag=7 -> out_ok=0, flt_cnt=1, ff_vld=1, ff_tag=7; second fault tag=8 leaves ff_tag=7.
REQ-038 out_rdy=0 for 4 cycles with 3 ops sent back-to-back -> in_rdy low after 2 accepted, out_tag stable, all 3 ops emitted in order after release.
REQ-039 flush asserted with s1 and s2 both valid -> out_vld=0 next cycle, no flt_cnt change, next op emerges with latency 2.
REQ-040 flt_cnt preloaded via 65535 faulting ops -> one more fault keeps 16'hFFFF; ff_clr same cycle as fault tag=3 -> ff_vld=1, ff_tag=3.
REQ-041 rst asserted asynchronously mid-stream (between edges) -> all outputs 0 immediately, flt_cnt=0, in_rdy=1 after release.
